// File: rtl/rgb2grey_axis.sv
// RGB to greyscale AXI-Stream converter: a 2-entry input skid buffer feeds a
// 3-stage luma pipeline (products, sum+round, shift+replicate) with a per-frame bypass mode.
`timescale 1ns/1ps
module rgb2grey_axis #(
  parameter int unsigned COEF_R = 77,
  parameter int unsigned COEF_G = 150,
  parameter int unsigned COEF_B = 29
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        s_axis_tvalid_i,
  output logic        s_axis_tready_o,
  input  logic [23:0] s_axis_tdata_i,
  input  logic        s_axis_tuser_i,
  output logic        m_axis_tvalid_o,
  input  logic        m_axis_tready_i,
  output logic [23:0] m_axis_tdata_o,
  output logic        m_axis_tuser_o,
  output logic        mode_o,
  output logic [15:0] frame_cnt_o
);
  localparam int DATA_W = 24;
  localparam int COEF_W = 8;
  localparam int PROD_W = 2 * COEF_W;
  localparam int SUM_W  = PROD_W + 1;
  localparam int WORD_W = DATA_W + 2;
  localparam logic [COEF_W-1:0] CR = COEF_W'(COEF_R);
  localparam logic [COEF_W-1:0] CG = COEF_W'(COEF_G);
  localparam logic [COEF_W-1:0] CB = COEF_W'(COEF_B);

  if ((COEF_R + COEF_G + COEF_B) != 256 || COEF_R > 255 || COEF_G > 255 || COEF_B > 255)
  begin : g_coef_check
    $error("rgb2grey_axis: luma weights must be 8-bit and sum to 256");
  end

  function automatic logic [SUM_W-1:0] round_sum(input logic [PROD_W-1:0] pr,
                                                 input logic [PROD_W-1:0] pg,
                                                 input logic [PROD_W-1:0] pb);
    return {1'b0, pr} + {1'b0, pg} + {1'b0, pb} + SUM_W'(128);
  endfunction

  // Weights sum to 256, so the top bit never sets; saturate defensively anyway.
  function automatic logic [COEF_W-1:0] sat_shift(input logic [SUM_W-1:0] s);
    return s[SUM_W-1] ? '1 : COEF_W'(s >> 8);
  endfunction

  logic [WORD_W-1:0] buf_q [2];
  logic [WORD_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              tready_q, tready_d;
  logic              mode_q, mode_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              in_hs, in_mode, push, pop, load_p0;
  logic              rdy_p0, rdy_p1, rdy_p2;
  logic [WORD_W-1:0] in_word, src_word;

  logic              vld_p0_q, vld_p0_d, user_p0_q, user_p0_d, grey_p0_q, grey_p0_d;
  logic [PROD_W-1:0] prod_r_p0_q, prod_r_p0_d, prod_g_p0_q, prod_g_p0_d;
  logic [PROD_W-1:0] prod_b_p0_q, prod_b_p0_d;
  logic [DATA_W-1:0] data_p0_q, data_p0_d;
  logic              vld_p1_q, vld_p1_d, user_p1_q, user_p1_d, grey_p1_q, grey_p1_d;
  logic [SUM_W-1:0]  sum_p1_q, sum_p1_d;
  logic [DATA_W-1:0] data_p1_q, data_p1_d;
  logic              vld_p2_q, vld_p2_d, user_p2_q, user_p2_d;
  logic [DATA_W-1:0] data_p2_q, data_p2_d;

  // Each pixel carries the mode it was accepted under, so a frame keeps its mode
  // even while an earlier frame is still draining from the pipeline.
  always_comb begin
    in_hs    = s_axis_tvalid_i & tready_q;
    in_mode  = s_axis_tuser_i ? enable_i : mode_q;
    in_word  = {in_mode, s_axis_tuser_i, s_axis_tdata_i};
    rdy_p2   = ~vld_p2_q | m_axis_tready_i;
    rdy_p1   = ~vld_p1_q | rdy_p2;
    rdy_p0   = ~vld_p0_q | rdy_p1;
    pop      = rdy_p0 & (cnt_q != 2'd0);
    push     = in_hs & ~(rdy_p0 & (cnt_q == 2'd0));
    load_p0  = pop | (in_hs & ~push);
    src_word = (cnt_q == 2'd0) ? in_word : buf_q[rd_ptr_q];
    buf_d    = buf_q;
    if (push) buf_d[wr_ptr_q] = in_word;
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop;
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    tready_d    = (cnt_d != 2'd2);
    mode_d      = (in_hs & s_axis_tuser_i) ? enable_i : mode_q;
    frame_cnt_d = frame_cnt_q + {15'd0, in_hs & s_axis_tuser_i};
  end

  always_comb begin
    // p0: per-channel products
    vld_p0_d    = rdy_p0 ? load_p0 : vld_p0_q;
    data_p0_d   = data_p0_q;
    user_p0_d   = user_p0_q;
    grey_p0_d   = grey_p0_q;
    prod_r_p0_d = prod_r_p0_q;
    prod_g_p0_d = prod_g_p0_q;
    prod_b_p0_d = prod_b_p0_q;
    if (load_p0) begin
      data_p0_d   = src_word[DATA_W-1:0];
      user_p0_d   = src_word[DATA_W];
      grey_p0_d   = src_word[DATA_W+1];
      prod_r_p0_d = PROD_W'(CR) * PROD_W'(src_word[7:0]);
      prod_g_p0_d = PROD_W'(CG) * PROD_W'(src_word[15:8]);
      prod_b_p0_d = PROD_W'(CB) * PROD_W'(src_word[23:16]);
    end
    // p1: sum with rounding offset
    vld_p1_d  = rdy_p1 ? vld_p0_q : vld_p1_q;
    sum_p1_d  = sum_p1_q;
    data_p1_d = data_p1_q;
    user_p1_d = user_p1_q;
    grey_p1_d = grey_p1_q;
    if (rdy_p1 & vld_p0_q) begin
      sum_p1_d  = round_sum(prod_r_p0_q, prod_g_p0_q, prod_b_p0_q);
      data_p1_d = data_p0_q;
      user_p1_d = user_p0_q;
      grey_p1_d = grey_p0_q;
    end
    // p2: shift, replicate or bypass
    vld_p2_d  = rdy_p2 ? vld_p1_q : vld_p2_q;
    data_p2_d = data_p2_q;
    user_p2_d = user_p2_q;
    if (rdy_p2 & vld_p1_q) begin
      data_p2_d = grey_p1_q ? {3{sat_shift(sum_p1_q)}} : data_p1_q;
      user_p2_d = user_p1_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tready_q    <= 1'b0;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      mode_q      <= 1'b0;
      frame_cnt_q <= 16'd0;
      vld_p0_q    <= 1'b0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      data_p2_q   <= '0;
      user_p2_q   <= 1'b0;
    end else begin
      tready_q    <= tready_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
      vld_p0_q    <= vld_p0_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      data_p2_q   <= data_p2_d;
      user_p2_q   <= user_p2_d;
    end
  end

  always_ff @(posedge clk_i) begin
    buf_q       <= buf_d;
    data_p0_q   <= data_p0_d;
    user_p0_q   <= user_p0_d;
    grey_p0_q   <= grey_p0_d;
    prod_r_p0_q <= prod_r_p0_d;
    prod_g_p0_q <= prod_g_p0_d;
    prod_b_p0_q <= prod_b_p0_d;
    sum_p1_q    <= sum_p1_d;
    data_p1_q   <= data_p1_d;
    user_p1_q   <= user_p1_d;
    grey_p1_q   <= grey_p1_d;
  end

  assign s_axis_tready_o = tready_q;
  assign m_axis_tvalid_o = vld_p2_q;
  assign m_axis_tdata_o  = data_p2_q;
  assign m_axis_tuser_o  = user_p2_q;
  assign mode_o          = mode_q;
  assign frame_cnt_o     = frame_cnt_q;
endmodule

// File: tb/tb_rgb2grey_axis.sv
// Bench for rgb2grey_axis: directed vectors plus a randomized stream checked
// against a queue-based reference model of the luma/bypass/frame rules.
`timescale 1ns/1ps
module tb_rgb2grey_axis;
  localparam int CR = 77, CG = 150, CB = 29;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic s_tvalid = 1'b0, s_tuser = 1'b0, m_tready = 1'b0;
  logic [23:0] s_tdata = '0;
  logic s_tready, m_tvalid, m_tuser, mode;
  logic [23:0] m_tdata;
  logic [15:0] fcnt;

  rgb2grey_axis dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable),
    .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
    .s_axis_tdata_i(s_tdata), .s_axis_tuser_i(s_tuser),
    .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tuser_o(m_tuser),
    .mode_o(mode), .frame_cnt_o(fcnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] d; logic u; int c; } exp_t;
  exp_t expq[$];
  exp_t ex;
  int n_cmp = 0, n_bad = 0, cyc = 0, out_cyc = 0;
  bit model_mode = 1'b0;
  logic [15:0] model_fcnt = 16'd0;
  logic hs_out, have_exp, was_stalled;
  logic [23:0] obs_d;
  logic obs_u;
  logic [25:0] snap;

  function automatic logic [23:0] ref_pix(input logic [23:0] d, input bit grey);
    int y;
    if (!grey) return d;
    y = (CR * int'(d[7:0]) + CG * int'(d[15:8]) + CB * int'(d[23:16]) + 128) / 256;
    return {3{y[7:0]}};
  endfunction

  // One clock cycle: log handshakes into the model, capture outputs, advance.
  task automatic step();
    hs_out = m_tvalid & m_tready;
    have_exp = 1'b0;
    if (s_tvalid & s_tready) begin
      if (s_tuser) begin
        model_mode = enable;
        model_fcnt = model_fcnt + 16'd1;
      end
      expq.push_back('{ref_pix(s_tdata, model_mode), s_tuser, cyc});
    end
    if (hs_out) begin
      obs_d = m_tdata;
      obs_u = m_tuser;
      out_cyc = cyc;
      if (expq.size() > 0) begin
        ex = expq.pop_front();
        have_exp = 1'b1;
      end
    end
    was_stalled = m_tvalid & ~m_tready;
    snap = {m_tvalid, m_tdata, m_tuser};
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL rst_tready: got %b expected 0", s_tready); end
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 24'h0) begin n_bad++; $display("FAIL rst_tdata: got %h expected 000000", m_tdata); end
    n_cmp++; if (m_tuser !== 1'b0) begin n_bad++; $display("FAIL rst_tuser: got %b expected 0", m_tuser); end
    n_cmp++; if (mode !== 1'b0) begin n_bad++; $display("FAIL rst_mode: got %b expected 0", mode); end
    n_cmp++; if (fcnt !== 16'h0) begin n_bad++; $display("FAIL rst_fcnt: got %h expected 0000", fcnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (s_tready !== 1'b0) begin n_bad++; $display("FAIL rel_tready_early: got %b expected 0", s_tready); end
    @(posedge clk); #1;
    n_cmp++; if (s_tready !== 1'b1) begin n_bad++; $display("FAIL rel_tready_edge: got %b expected 1", s_tready); end
  endtask

  task automatic test_bypass();
    int got = 0;
    logic acc;
    enable = 1'b0; m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 24'h123456; s_tuser = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = s_tvalid & s_tready;
      step();
      if (acc) begin s_tvalid = 1'b0; s_tuser = 1'b0; end
      if (hs_out) begin
        got++;
        n_cmp++; if (obs_d !== 24'h123456 || obs_u !== 1'b1) begin
          n_bad++; $display("FAIL bypass_data: got %h/%b expected 123456/1", obs_d, obs_u); end
        n_cmp++; if (!have_exp || out_cyc - ex.c != 3) begin
          n_bad++; $display("FAIL bypass_latency: got %0d expected 3", out_cyc - ex.c); end
      end
    end
    n_cmp++; if (got != 1) begin n_bad++; $display("FAIL bypass_count: got %0d expected 1", got); end
    n_cmp++; if (fcnt !== 16'd1) begin n_bad++; $display("FAIL bypass_fcnt: got %h expected 0001", fcnt); end
  endtask

  task automatic test_grey_vectors();
    logic [23:0] vin [4];
    logic [23:0] vexp [4];
    int idx = 0, k = 0;
    logic acc;
    vin = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF};
    vexp = '{24'h4D4D4D, 24'h959595, 24'h1D1D1D, 24'hFFFFFF};
    enable = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      s_tvalid = (idx < 4);
      s_tdata = (idx < 4) ? vin[idx] : 24'h0;
      s_tuser = (idx == 0);
      acc = s_tvalid & s_tready;
      step();
      if (acc) idx++;
      if (hs_out && k < 4) begin
        n_cmp++; if (obs_d !== vexp[k]) begin
          n_bad++; $display("FAIL grey_vec%0d: got %h expected %h", k, obs_d, vexp[k]); end
        n_cmp++; if (!have_exp || out_cyc - ex.c != 3) begin
          n_bad++; $display("FAIL grey_latency%0d: got %0d expected 3", k, out_cyc - ex.c); end
        k++;
      end
    end
    s_tvalid = 1'b0; s_tuser = 1'b0;
    n_cmp++; if (k != 4) begin n_bad++; $display("FAIL grey_count: got %0d expected 4", k); end
    n_cmp++; if (mode !== 1'b1) begin n_bad++; $display("FAIL grey_mode: got %b expected 1", mode); end
  endtask

  task automatic test_mode_switch();
    logic [23:0] pix [11];
    int idx = 0, k = 0;
    logic acc;
    for (int i = 0; i < 11; i++) pix[i] = 24'($urandom()) | 24'h000100;
    enable = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 40 && k < 11; i++) begin
      s_tvalid = (idx < 11);
      s_tdata = (idx < 11) ? pix[idx] : 24'h0;
      s_tuser = (idx == 0) || (idx == 8);
      enable = (idx >= 4);
      if (idx == 8) begin
        n_cmp++; if (mode !== 1'b0) begin n_bad++; $display("FAIL mode_before_sof: got %b expected 0", mode); end
      end
      acc = s_tvalid & s_tready;
      step();
      if (acc) begin
        idx++;
        n_cmp++; if (mode !== model_mode) begin
          n_bad++; $display("FAIL mode_track%0d: got %b expected %b", idx, mode, model_mode); end
      end
      if (hs_out) begin
        n_cmp++; if (!have_exp || obs_d !== ex.d || obs_u !== ex.u) begin
          n_bad++; $display("FAIL mode_pix%0d: got %h/%b expected %h/%b", k, obs_d, obs_u, ex.d, ex.u); end
        if (k >= 4 && k < 8) begin
          n_cmp++; if (obs_d !== pix[k]) begin
            n_bad++; $display("FAIL mode_midframe%0d: got %h expected %h", k, obs_d, pix[k]); end
        end
        k++;
      end
    end
    s_tvalid = 1'b0; s_tuser = 1'b0;
    n_cmp++; if (k != 11) begin n_bad++; $display("FAIL mode_count: got %0d expected 11", k); end
    n_cmp++; if (mode !== 1'b1) begin n_bad++; $display("FAIL mode_final: got %b expected 1", mode); end
  endtask

  task automatic test_random();
    int sent = 0, outs = 0, budget = 0;
    logic acc;
    s_tvalid = 1'b0; s_tuser = 1'b0;
    while ((sent < 1000 || expq.size() > 0) && budget < 20000) begin
      if (!s_tvalid && sent < 1000 && $urandom_range(3) != 0) begin
        s_tvalid = 1'b1;
        s_tdata = 24'($urandom());
        s_tuser = (sent == 0) || ($urandom_range(19) == 0);
      end
      if ($urandom_range(7) == 0) enable = ~enable;
      m_tready = ($urandom_range(9) < 6);
      acc = s_tvalid & s_tready;
      step();
      budget++;
      if (acc) begin sent++; s_tvalid = 1'b0; s_tuser = 1'b0; end
      if (hs_out) begin
        outs++;
        n_cmp++;
        if (!have_exp) begin n_bad++; $display("FAIL rand_extra: got %h expected none", obs_d); end
        else if (obs_d !== ex.d || obs_u !== ex.u) begin
          n_bad++; $display("FAIL rand_pix%0d: got %h/%b expected %h/%b", outs, obs_d, obs_u, ex.d, ex.u); end
      end
      if (was_stalled) begin
        n_cmp++; if ({m_tvalid, m_tdata, m_tuser} !== snap) begin
          n_bad++; $display("FAIL rand_stall: got %h expected %h", {m_tvalid, m_tdata, m_tuser}, snap); end
      end
    end
    s_tvalid = 1'b0; m_tready = 1'b1;
    n_cmp++; if (budget >= 20000) begin n_bad++; $display("FAIL rand_timeout: got %0d cycles expected fewer than 20000", budget); end
    n_cmp++; if (outs != 1000) begin n_bad++; $display("FAIL rand_count: got %0d expected 1000", outs); end
    n_cmp++; if (fcnt !== model_fcnt) begin n_bad++; $display("FAIL rand_fcnt: got %h expected %h", fcnt, model_fcnt); end
  endtask

  task automatic test_reset_inflight();
    int acc_n = 0, seen = 0;
    logic acc;
    m_tready = 1'b0; enable = 1'b1;
    for (int i = 0; i < 10 && acc_n < 3; i++) begin
      s_tvalid = 1'b1; s_tdata = 24'($urandom()); s_tuser = (acc_n == 0);
      acc = s_tvalid & s_tready;
      step();
      if (acc) acc_n++;
    end
    s_tvalid = 1'b0; s_tuser = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (m_tvalid !== 1'b0) begin n_bad++; $display("FAIL inflight_tvalid: got %b expected 0", m_tvalid); end
    n_cmp++; if (m_tdata !== 24'h0) begin n_bad++; $display("FAIL inflight_tdata: got %h expected 000000", m_tdata); end
    expq.delete(); model_mode = 1'b0; model_fcnt = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_tvalid) seen++;
      step();
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL inflight_leak: got %0d outputs expected 0", seen); end
    n_cmp++; if (fcnt !== 16'h0) begin n_bad++; $display("FAIL inflight_fcnt: got %h expected 0000", fcnt); end
  endtask

  task automatic test_frame_wrap();
    int k = 0;
    logic acc;
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    model_fcnt = 16'hFFFF;
    enable = 1'b1; m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 24'h336699; s_tuser = 1'b1;
    for (int i = 0; i < 8; i++) begin
      acc = s_tvalid & s_tready;
      step();
      if (acc) begin s_tvalid = 1'b0; s_tuser = 1'b0; end
      if (hs_out) begin
        k++;
        n_cmp++; if (!have_exp || obs_d !== ex.d) begin
          n_bad++; $display("FAIL wrap_pix: got %h expected %h", obs_d, ex.d); end
      end
    end
    n_cmp++; if (fcnt !== 16'h0000) begin n_bad++; $display("FAIL wrap_fcnt: got %h expected 0000", fcnt); end
    n_cmp++; if (k != 1) begin n_bad++; $display("FAIL wrap_count: got %0d expected 1", k); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_grey_vectors();
    test_mode_switch();
    test_random();
    test_reset_inflight();
    test_frame_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
